// File: rtl/scramble_sequencer_if.sv
// Bundle of the sequencer's conditioned inputs and cell-array controls.
// master = input conditioning / cell side, slave = scramble_sequencer.
interface scramble_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             scramble_req;
  logic [2:0]       rnd;
  logic [3:0]       user_sel;
  logic             user_nrow;
  logic             user_fire;
  logic             user_error;
  logic             win;
  logic [3:0]       row_en;
  logic [3:0]       col_en;
  logic             fire;
  logic             user_move;
  logic             busy;
  logic             buzz_en;
  logic [CNT_W-1:0] moves_left;

  modport master (
    output scramble_req, rnd, user_sel, user_nrow, user_fire, user_error, win,
    input  row_en, col_en, fire, user_move, busy, buzz_en, moves_left
  );

  modport slave (
    input  scramble_req, rnd, user_sel, user_nrow, user_fire, user_error, win,
    output row_en, col_en, fire, user_move, busy, buzz_en, moves_left
  );
endinterface

// File: rtl/scramble_sequencer.sv
// Arbitrates row/col flips between the random scrambler and the player; watches for a win.
// Optional macro SCRAMBLE_NO_REPEAT_EN: rotate a scramble move that repeats the previous one.
module scramble_sequencer #(
  parameter int NUM_MOVES  = 16,
  parameter int GAP_CYCLES = 15,
  parameter int CNT_W      = 8
) (
  input logic                 clk,
  input logic                 reset,
  scramble_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCRAMBLE,
    S_SETTLE,
    S_PLAY,
    S_WON
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] moves_left_q, moves_left_d;
  logic [3:0]       row_en_q, row_en_d;
  logic [3:0]       col_en_q, col_en_d;
  logic             fire_q, fire_d;
  logic             user_move_q, user_move_d;
  logic             busy_q, buzz_en_q;
  logic             guard_q;        // blocks all requests in the first cycle after reset
  logic             start_scr;
  logic             scr_fire;
  logic             user_ok;
  logic [2:0]       mv;

`ifdef SCRAMBLE_NO_REPEAT_EN
  logic       prev_valid_q;
  logic [2:0] prev_mv_q;

  always_comb begin
    mv = bus.rnd;
    if (prev_valid_q && (bus.rnd == prev_mv_q)) mv[1:0] = bus.rnd[1:0] + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid_q <= 1'b0;
      prev_mv_q    <= '0;
    end else if (start_scr) begin
      prev_valid_q <= 1'b0;
    end else if (scr_fire) begin
      prev_valid_q <= 1'b1;
      prev_mv_q    <= mv;
    end
  end
`else
  assign mv = bus.rnd;
`endif

  assign user_ok = bus.user_fire & ~bus.user_error & (|bus.user_sel);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    gap_d        = gap_q;
    moves_left_d = moves_left_q;
    fire_d       = 1'b0;
    row_en_d     = '0;
    col_en_d     = '0;
    user_move_d  = 1'b0;
    start_scr    = 1'b0;
    scr_fire     = 1'b0;

    unique case (state_q)
      S_IDLE, S_PLAY: begin
        if (!guard_q) begin
          if (bus.scramble_req) begin
            start_scr = 1'b1;
          end else begin
            if (user_ok) begin
              fire_d      = 1'b1;
              user_move_d = 1'b1;
              row_en_d    = bus.user_nrow ? 4'b0000 : bus.user_sel;
              col_en_d    = bus.user_nrow ? bus.user_sel : 4'b0000;
            end
            if ((state_q == S_PLAY) && bus.win) state_d = S_WON;
          end
        end
      end
      S_SCRAMBLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - CNT_W'(1);
        end else begin
          scr_fire     = 1'b1;
          fire_d       = 1'b1;
          row_en_d     = mv[2] ? 4'b0000 : (4'b0001 << mv[1:0]);
          col_en_d     = mv[2] ? (4'b0001 << mv[1:0]) : 4'b0000;
          moves_left_d = moves_left_q - CNT_W'(1);
          gap_d        = CNT_W'(GAP_CYCLES);
          if (moves_left_q == CNT_W'(1)) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (gap_q != '0) gap_d = gap_q - CNT_W'(1);
        else if (bus.win) start_scr = 1'b1;   // scramble cancelled itself out
        else state_d = S_PLAY;
      end
      S_WON: begin
        if (bus.scramble_req) start_scr = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_scr) begin
      state_d      = S_SCRAMBLE;
      moves_left_d = CNT_W'(NUM_MOVES);
      gap_d        = CNT_W'(GAP_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      moves_left_q <= '0;
      row_en_q     <= '0;
      col_en_q     <= '0;
      fire_q       <= 1'b0;
      user_move_q  <= 1'b0;
      busy_q       <= 1'b0;
      buzz_en_q    <= 1'b0;
      guard_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      moves_left_q <= moves_left_d;
      row_en_q     <= row_en_d;
      col_en_q     <= col_en_d;
      fire_q       <= fire_d;
      user_move_q  <= user_move_d;
      busy_q       <= (state_d == S_SCRAMBLE) || (state_d == S_SETTLE);
      buzz_en_q    <= (state_d == S_WON);
      guard_q      <= 1'b0;
    end
  end

  assign bus.row_en     = row_en_q;
  assign bus.col_en     = col_en_q;
  assign bus.fire       = fire_q;
  assign bus.user_move  = user_move_q;
  assign bus.busy       = busy_q;
  assign bus.buzz_en    = buzz_en_q;
  assign bus.moves_left = moves_left_q;

endmodule
